// File: rtl/serial_divider_5bits_pkg.sv
// Shared widths, iteration count and state encoding for the serial 5-bit divider.
package serial_divider_5bits_pkg;

    localparam int WIDTH      = 5;
    localparam int ITERATIONS = 5;

    // Counter value on the final RUN cycle; the counter is 3 bits wide.
    localparam logic [2:0] LAST_ITER = 3'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_divider_5bits_if.sv
// Requester/consumer handshake bundle for the serial divider.
interface serial_divider_5bits_if;
    import serial_divider_5bits_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/serial_divider_5bits_subtractor.sv
// 5-bit two's-complement subtractor a - b; overflow_o is the adder carry-out,
// which is 1 exactly when no borrow occurred (a >= b unsigned).
module subtractor_5bits (
    input  logic [4:0] a_i,
    input  logic [4:0] b_i,
    output logic [4:0] diff_o,
    output logic       overflow_o
);

    logic [5:0] sum;

    assign sum        = {1'b0, a_i} + {1'b0, ~b_i} + 6'd1;
    assign diff_o     = sum[4:0];
    assign overflow_o = sum[5];

endmodule

// File: rtl/serial_divider_5bits.sv
// Restoring divider controller: one trial subtraction per clock on a shared subtractor.
//
//   state | meaning
//   IDLE  | waiting for start; results held
//   RUN   | one quotient bit per cycle, MSB first
//   DONE  | results valid, done pulses for this cycle
module serial_divider_5bits
    import serial_divider_5bits_pkg::*;
#(
    parameter logic [WIDTH-1:0] DBZ_QUOTIENT = 5'b11111
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_divider_5bits_if.slave  bus
);

    state_e           state_q;
    logic [2:0]       count_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;

    // rem_q[4] is always 0 here: the partial remainder is bounded by a dividend prefix.
    always_comb begin
        shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        rem_d   = no_borrow ? diff : shifted;
        quo_d   = {quo_q[WIDTH-2:0], no_borrow};
    end

    subtractor_5bits u_sub (
        .a_i        (shifted),
        .b_i        (divisor_q),
        .diff_o     (diff),
        .overflow_o (no_borrow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            divisor_q <= bus.divisor;
                            quo_q     <= bus.dividend;
                            rem_q     <= '0;
                            count_q   <= '0;
                            dbz_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= RUN;
                        end else begin
                            quotient_q  <= DBZ_QUOTIENT;
                            remainder_q <= bus.dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                RUN: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + 3'd1;
                    if (count_q == LAST_ITER) begin
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
